// File: rtl/sprite_palette_bank.sv
// Multi-palette runtime-writable colour lookup with one-cycle registered output.
// Optional macro PALETTE_FADE_EN enables a per-frame right-shift fade of the output colour.
module sprite_palette_bank #(
   parameter int unsigned IDX_W           = 4,
   parameter int unsigned CH_W            = 4,
   parameter int unsigned NUM_PAL         = 4,
   parameter int unsigned TRANSPARENT_IDX = 0,
   localparam int unsigned PW = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
   input  logic                Clk,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic [PW-1:0]       wr_pal,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [3*CH_W-1:0]   wr_rgb,
   input  logic [PW-1:0]       pal_sel,
   input  logic [1:0]          fade,
   input  logic                frame_start,
   input  logic                px_valid,
   input  logic [IDX_W-1:0]    px_idx,
   output logic                out_valid,
   output logic [CH_W-1:0]     red,
   output logic [CH_W-1:0]     green,
   output logic [CH_W-1:0]     blue,
   output logic                out_transparent
);

   localparam int unsigned ENTRIES = 1 << IDX_W;
   localparam int unsigned RGB_W   = 3 * CH_W;
   localparam int unsigned SHIFT   = CH_W - IDX_W;
   localparam logic [PW:0] NUM_PAL_W = (PW + 1)'(NUM_PAL);
   localparam logic [IDX_W-1:0] TRANSP_W = IDX_W'(TRANSPARENT_IDX);

   // Reset contents: grey ramp scaled to the channel width.
   function automatic logic [RGB_W-1:0] grey(input int unsigned i);
      logic [CH_W-1:0] ch;
      ch = CH_W'(i) << SHIFT;
      return {ch, ch, ch};
   endfunction

   logic [RGB_W-1:0] mem_q [NUM_PAL][ENTRIES];
   logic [RGB_W-1:0] mem_d [NUM_PAL][ENTRIES];
   logic [PW-1:0]    active_pal_q, active_pal_d;
   logic             out_valid_q, out_valid_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             transp_q, transp_d;
   logic             wr_ok;
   logic             bypass;
   logic [RGB_W-1:0] entry;
   logic [RGB_W-1:0] shaded;

   assign wr_ok  = wr_en && ({1'b0, wr_pal} < NUM_PAL_W);
   assign bypass = wr_en && (wr_pal == active_pal_q) && (wr_idx == px_idx);

`ifdef PALETTE_FADE_EN
   logic [1:0] fade_q, fade_d;

   always_comb begin
      fade_d = fade_q;
      if (frame_start) fade_d = fade;
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) fade_q <= 2'd0;
      else          fade_q <= fade_d;
   end

   assign shaded = {entry[RGB_W-1 -: CH_W] >> fade_q,
                    entry[2*CH_W-1 -: CH_W] >> fade_q,
                    entry[CH_W-1 -: CH_W] >> fade_q};
`else
   logic unused_fade;
   assign unused_fade = ^fade;
   assign shaded      = entry;
`endif

   // Palette storage next-state and frame-boundary palette switch.
   always_comb begin
      mem_d = mem_q;
      if (wr_ok) mem_d[wr_pal][wr_idx] = wr_rgb;
      active_pal_d = active_pal_q;
      if (frame_start && ({1'b0, pal_sel} < NUM_PAL_W)) active_pal_d = pal_sel;
   end

   // Lookup with write-first bypass against the current active palette.
   always_comb begin
      entry = mem_q[active_pal_q][px_idx];
      if (bypass) entry = wr_rgb;
      out_valid_d = px_valid;
      rgb_d       = rgb_q;
      transp_d    = transp_q;
      if (px_valid) begin
         rgb_d    = shaded;
         transp_d = (px_idx == TRANSP_W);
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned p = 0; p < NUM_PAL; p++) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
               mem_q[p][i] <= grey(i);
            end
         end
         active_pal_q <= '0;
         out_valid_q  <= 1'b0;
         rgb_q        <= '0;
         transp_q     <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         active_pal_q <= active_pal_d;
         out_valid_q  <= out_valid_d;
         rgb_q        <= rgb_d;
         transp_q     <= transp_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign red             = rgb_q[RGB_W-1 -: CH_W];
   assign green           = rgb_q[2*CH_W-1 -: CH_W];
   assign blue            = rgb_q[CH_W-1 -: CH_W];
   assign out_transparent = transp_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed plus random scoreboard bench for sprite_palette_bank (NUM_PAL=3 so an out-of-range palette exists).
module tb_sprite_palette_bank;

   logic        Clk;
   logic        reset_n;
   logic        wr_en;
   logic [1:0]  wr_pal;
   logic [3:0]  wr_idx;
   logic [11:0] wr_rgb;
   logic [1:0]  pal_sel;
   logic [1:0]  fade;
   logic        frame_start;
   logic        px_valid;
   logic [3:0]  px_idx;
   logic        out_valid;
   logic [3:0]  red, green, blue;
   logic        out_transparent;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        v;
      logic [11:0] rgb;
      logic        t;
   } exp_t;

   exp_t        sb_q[$];
   logic [11:0] m_mem [3][16];
   logic [1:0]  m_act;
   logic [1:0]  m_fade;
   logic [11:0] m_rgb;
   logic        m_t;

   sprite_palette_bank #(
      .IDX_W(4), .CH_W(4), .NUM_PAL(3), .TRANSPARENT_IDX(0)
   ) dut (
      .Clk(Clk), .reset_n(reset_n),
      .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
      .pal_sel(pal_sel), .fade(fade), .frame_start(frame_start),
      .px_valid(px_valid), .px_idx(px_idx),
      .out_valid(out_valid), .red(red), .green(green), .blue(blue),
      .out_transparent(out_transparent)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 16; i++) begin
            logic [3:0] c;
            c = 4'(i);
            m_mem[p][i] = {c, c, c};
         end
      m_act  = 2'd0;
      m_fade = 2'd0;
      m_rgb  = 12'h000;
      m_t    = 1'b0;
      sb_q.delete();
   endtask

   // Drive one cycle of inputs, predict, advance one edge, then compare.
   task automatic step(input string tag, input logic we, input logic [1:0] wp,
                       input logic [3:0] wi, input logic [11:0] wd, input logic fs,
                       input logic [1:0] ps, input logic [1:0] fd, input logic pv,
                       input logic [3:0] pi);
      exp_t        x;
      logic [11:0] e;
      logic [1:0]  sh;
      exp_t        got;
      wr_en = we; wr_pal = wp; wr_idx = wi; wr_rgb = wd;
      frame_start = fs; pal_sel = ps; fade = fd;
      px_valid = pv; px_idx = pi;
`ifdef PALETTE_FADE_EN
      sh = m_fade;
`else
      sh = 2'd0;
`endif
      e = m_mem[m_act][pi];
      if (we && wp == m_act && wi == pi) e = wd;
      e = {e[11:8] >> sh, e[7:4] >> sh, e[3:0] >> sh};
      if (pv) begin
         m_rgb = e;
         m_t   = (pi == 4'd0);
      end
      x = '{v: pv, rgb: m_rgb, t: m_t};
      sb_q.push_back(x);
      if (we && wp < 2'd3) m_mem[wp][wi] = wd;
      if (fs) begin
         if (ps < 2'd3) m_act = ps;
         m_fade = fd;
      end
      @(posedge Clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         got = sb_q.pop_front();
         chk({tag, "_valid"}, 32'(out_valid), 32'(got.v));
         chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(got.rgb));
         chk({tag, "_transp"}, 32'(out_transparent), 32'(got.t));
      end
   endtask

   initial begin
      reset_n = 1'b0;
      wr_en = 1'b0; wr_pal = 2'd0; wr_idx = 4'd0; wr_rgb = 12'h000;
      pal_sel = 2'd0; fade = 2'd0; frame_start = 1'b0; px_valid = 1'b0; px_idx = 4'd0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_rgb", 32'({red, green, blue}), 32'h000);
      chk("rst_transp", 32'(out_transparent), 32'd0);
      reset_n = 1'b1;

      step("grey5", 0, 0, 0, 0, 0, 0, 0, 1, 4'd5);
      chk("grey5_const", 32'({red, green, blue}), 32'h555);
      step("grey0", 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
      chk("transp_const", 32'(out_transparent), 32'd1);
      step("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0, 4'd9);
      step("wr_e83", 1, 0, 4'd3, 12'hE83, 0, 0, 0, 0, 4'd0);
      step("rd_e83", 0, 0, 0, 0, 0, 0, 0, 1, 4'd3);
      chk("rd_e83_const", 32'({red, green, blue}), 32'hE83);
      step("wr_badpal", 1, 2'd3, 4'd3, 12'h123, 0, 0, 0, 0, 4'd0);
      step("rd_after_bad", 0, 0, 0, 0, 0, 0, 0, 1, 4'd3);
      chk("badpal_const", 32'({red, green, blue}), 32'hE83);
      step("bypass", 1, 0, 4'd7, 12'hD53, 0, 0, 0, 1, 4'd7);
      chk("bypass_const", 32'({red, green, blue}), 32'hD53);
      step("no_bypass", 1, 1, 4'd6, 12'h111, 0, 0, 0, 1, 4'd6);
      chk("no_bypass_const", 32'({red, green, blue}), 32'h666);
      step("wr_abc", 1, 2, 4'd1, 12'hABC, 0, 0, 0, 0, 4'd0);
      step("fs_old_pal", 0, 0, 0, 0, 1, 2'd2, 0, 1, 4'd1);
      chk("fs_old_const", 32'({red, green, blue}), 32'h111);
      step("fs_new_pal", 0, 0, 0, 0, 0, 0, 0, 1, 4'd1);
      chk("fs_new_const", 32'({red, green, blue}), 32'hABC);
      step("fs_bad_sel", 0, 0, 0, 0, 1, 2'd3, 0, 0, 4'd0);
      step("after_bad_sel", 0, 0, 0, 0, 0, 0, 0, 1, 4'd1);
      chk("bad_sel_const", 32'({red, green, blue}), 32'hABC);
      step("fs_wr_nobyp", 1, 1, 4'd2, 12'hFFF, 1, 2'd1, 0, 1, 4'd2);
      chk("fs_wr_nobyp_const", 32'({red, green, blue}), 32'h222);
      step("fs_wr_after", 0, 0, 0, 0, 0, 0, 0, 1, 4'd2);
      chk("fs_wr_after_const", 32'({red, green, blue}), 32'hFFF);
      step("wr_f84", 1, 1, 4'd4, 12'hF84, 1, 2'd1, 2'd2, 0, 4'd0);
      step("fade_rd", 0, 0, 0, 0, 0, 0, 0, 1, 4'd4);
`ifdef PALETTE_FADE_EN
      chk("fade_const", 32'({red, green, blue}), 32'h321);
`else
      chk("fade_const", 32'({red, green, blue}), 32'hF84);
`endif

      for (int n = 0; n < 60; n++) begin
         step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 12'($urandom),
              ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)));
      end

      step("wr_pre_rst", 1, 0, 4'd3, 12'h9A5, 1, 2'd0, 2'd0, 1, 4'd8);
      step("stream_pre_rst", 0, 0, 0, 0, 0, 0, 0, 1, 4'd3);
      px_valid = 1'b1; px_idx = 4'd9; wr_en = 1'b0; frame_start = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_rgb", 32'({red, green, blue}), 32'h000);
      chk("async_rst_transp", 32'(out_transparent), 32'd0);
      model_reset();
      @(posedge Clk);
      #1;
      chk("rst_hold_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b1;
      step("post_rst_grey", 0, 0, 0, 0, 0, 0, 0, 1, 4'd3);
      chk("post_rst_const", 32'({red, green, blue}), 32'h333);
      step("post_rst_pal0", 0, 0, 0, 0, 0, 0, 0, 1, 4'd4);
      chk("post_rst_pal0_const", 32'({red, green, blue}), 32'h444);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
